// File: rtl/timer_periph_pkg.sv
// Shared register offsets and TCON field positions for the multi-channel timer peripheral.
package timer_periph_pkg;

    localparam logic [31:0] OFF_TH      = 32'h0000_0000;
    localparam logic [31:0] OFF_TL      = 32'h0000_0004;
    localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
    localparam logic [31:0] OFF_SYSTICK = 32'h0000_0100;
    localparam logic [31:0] OFF_IRQSTAT = 32'h0000_0104;
    localparam int          CH_STRIDE   = 16;

    localparam int TCON_EN      = 0;
    localparam int TCON_IE      = 1;
    localparam int TCON_PEND    = 2;
    localparam int TCON_ONESHOT = 3;

    localparam int PSC_LSB = 8;
    localparam int PSC_MSB = 15;

endpackage

// File: rtl/timer_periph_mc_channel.sv
// One reload timer channel: TH/TL/TCON, counter, optional prescaler (TIMER_PRESCALE_EN)
// and the bus-write versus count collision rules.
module timer_channel
    import timer_periph_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_th,
    input  logic              i_wr_tl,
    input  logic              i_wr_tcon,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_th,
    output logic [DATA_W-1:0] o_tl,
    output logic [DATA_W-1:0] o_tcon,
    output logic              o_pend,
    output logic              o_irq
);

    logic [DATA_W-1:0] r_th;
    logic [DATA_W-1:0] r_tl;
    logic              r_en;
    logic              r_ie;
    logic              r_pend;
    logic              r_oneshot;
    logic              w_tick;
    logic              w_term;

`ifdef TIMER_PRESCALE_EN
    logic [7:0] r_psc;
    logic [7:0] r_div;

    assign w_tick = r_en && (r_div == r_psc);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_psc <= '0;
            r_div <= '0;
        end else if (i_wr_tcon) begin
            r_psc <= i_wdata[PSC_MSB:PSC_LSB];
            r_div <= '0;
        end else if (!r_en || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 8'd1;
        end
    end
`else
    assign w_tick = r_en;
`endif

    assign w_term = w_tick && (r_tl == '1);

    // Later assignments win: bus writes override counting, terminal PEND-set overrides W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_th      <= '0;
            r_tl      <= '0;
            r_en      <= 1'b0;
            r_ie      <= 1'b0;
            r_pend    <= 1'b0;
            r_oneshot <= 1'b0;
        end else begin
            if (w_tick) r_tl <= w_term ? r_th : r_tl + DATA_W'(1);
            if (w_term && r_oneshot) r_en <= 1'b0;
            if (i_wr_tl) r_tl <= i_wdata;
            if (i_wr_th) r_th <= i_wdata;
            if (i_wr_tcon) begin
                r_en      <= i_wdata[TCON_EN];
                r_ie      <= i_wdata[TCON_IE];
                r_oneshot <= i_wdata[TCON_ONESHOT];
                if (i_wdata[TCON_PEND]) r_pend <= 1'b0;
            end
            if (w_term) r_pend <= 1'b1;
        end
    end

    always_comb begin
        o_tcon               = '0;
        o_tcon[TCON_EN]      = r_en;
        o_tcon[TCON_IE]      = r_ie;
        o_tcon[TCON_PEND]    = r_pend;
        o_tcon[TCON_ONESHOT] = r_oneshot;
`ifdef TIMER_PRESCALE_EN
        o_tcon[PSC_MSB:PSC_LSB] = r_psc;
`endif
    end

    assign o_th   = r_th;
    assign o_tl   = r_tl;
    assign o_pend = r_pend;
    assign o_irq  = r_pend && r_ie;

endmodule

// File: rtl/timer_periph_mc.sv
// Multi-channel timer peripheral top: address decode, read mux, systick and interrupt combine.
// Optional per-channel prescaler is enabled by defining TIMER_PRESCALE_EN.
module timer_periph_mc
    import timer_periph_pkg::*;
#(
    parameter int          NUM_TIMERS = 2,
    parameter int          DATA_W     = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [31:0]           addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    input  logic                  irq_mask,
    output logic                  irqout,
    output logic [NUM_TIMERS-1:0] irq_vec
);

    logic [31:0]           w_off;
    logic                  w_ch_hit;
    logic [2:0]            w_ch_idx;
    logic [3:0]            w_reg;
    logic [NUM_TIMERS-1:0] w_wr_th;
    logic [NUM_TIMERS-1:0] w_wr_tl;
    logic [NUM_TIMERS-1:0] w_wr_tcon;
    logic [NUM_TIMERS-1:0] w_pend;
    logic [NUM_TIMERS-1:0] w_irq;
    logic [DATA_W-1:0]     w_th   [NUM_TIMERS];
    logic [DATA_W-1:0]     w_tl   [NUM_TIMERS];
    logic [DATA_W-1:0]     w_tcon [NUM_TIMERS];
    logic [DATA_W-1:0]     r_systick;

    // Addresses below BASE_ADDR wrap to huge offsets and fall outside every window.
    assign w_off    = addr - BASE_ADDR;
    assign w_ch_hit = w_off < 32'(NUM_TIMERS * CH_STRIDE);
    assign w_ch_idx = w_off[6:4];
    assign w_reg    = w_off[3:0];

    always_comb begin
        w_wr_th   = '0;
        w_wr_tl   = '0;
        w_wr_tcon = '0;
        for (int n = 0; n < NUM_TIMERS; n++) begin
            if (wr && w_ch_hit && (w_ch_idx == n[2:0])) begin
                w_wr_th[n]   = (w_reg == OFF_TH[3:0]);
                w_wr_tl[n]   = (w_reg == OFF_TL[3:0]);
                w_wr_tcon[n] = (w_reg == OFF_TCON[3:0]);
            end
        end
    end

    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_ch
        timer_channel #(
            .DATA_W (DATA_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .i_wr_th   (w_wr_th[g]),
            .i_wr_tl   (w_wr_tl[g]),
            .i_wr_tcon (w_wr_tcon[g]),
            .i_wdata   (wdata),
            .o_th      (w_th[g]),
            .o_tl      (w_tl[g]),
            .o_tcon    (w_tcon[g]),
            .o_pend    (w_pend[g]),
            .o_irq     (w_irq[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) r_systick <= '0;
        else       r_systick <= r_systick + DATA_W'(1);
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (w_off == OFF_SYSTICK) begin
                rdata = r_systick;
            end else if (w_off == OFF_IRQSTAT) begin
                rdata = DATA_W'(w_pend);
            end else if (w_ch_hit) begin
                for (int n = 0; n < NUM_TIMERS; n++) begin
                    if (w_ch_idx == n[2:0]) begin
                        case (w_reg)
                            OFF_TH[3:0]:   rdata = w_th[n];
                            OFF_TL[3:0]:   rdata = w_tl[n];
                            OFF_TCON[3:0]: rdata = w_tcon[n];
                            default:       rdata = '0;
                        endcase
                    end
                end
            end
        end
    end

    assign irq_vec = w_irq;
    assign irqout  = (|w_irq) & ~irq_mask;

endmodule

// File: tb/tb_timer_periph_mc.sv
// Directed testbench for timer_periph_mc; covers the TIMER_PRESCALE_EN build when the macro is defined.
module tb_timer_periph_mc;

    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [31:0] A_TH0  = BASE + 32'h00;
    localparam logic [31:0] A_TL0  = BASE + 32'h04;
    localparam logic [31:0] A_TC0  = BASE + 32'h08;
    localparam logic [31:0] A_TH1  = BASE + 32'h10;
    localparam logic [31:0] A_TL1  = BASE + 32'h14;
    localparam logic [31:0] A_TC1  = BASE + 32'h18;
    localparam logic [31:0] A_SYS  = BASE + 32'h100;
    localparam logic [31:0] A_IRQS = BASE + 32'h104;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq_mask = 1'b0;
    logic        irqout;
    logic [1:0]  irq_vec;

    int n_cmp = 0;
    int n_err = 0;

    timer_periph_mc #(
        .NUM_TIMERS (2),
        .DATA_W     (32),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq_mask (irq_mask),
        .irqout   (irqout),
        .irq_vec  (irq_vec)
    );

    always #5 clk = ~clk;

    // Called at posedge+1; returns at posedge+1 after the write edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(posedge clk);
        #1;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        rd   = 1'b1;
        #1;
        d    = rdata;
        rd   = 1'b0;
        addr = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        bus_write(A_TH0, 32'd5);
        bus_write(A_TC0, 32'h3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_read(A_TH0, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_th: got %h expected %h", v, 32'h0); end
        bus_read(A_TL0, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_tl: got %h expected %h", v, 32'h0); end
        bus_read(A_TC0, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_tcon: got %h expected %h", v, 32'h0); end
        bus_read(A_SYS, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_systick: got %h expected %h", v, 32'h0); end
        n_cmp++; if (irqout !== 1'b0) begin n_err++; $display("FAIL reset_irqout: got %b expected 0", irqout); end
    endtask

    task automatic test_periodic;
        logic [31:0] v;
        bus_write(A_TH0, 32'hFFFF_FFFD);
        bus_write(A_TL0, 32'hFFFF_FFFD);
        bus_write(A_TC0, 32'h3);
        bus_read(A_TL0, v);
        n_cmp++; if (v !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL per_tl_start: got %h expected %h", v, 32'hFFFF_FFFD); end
        tick(2);
        bus_read(A_TL0, v);
        n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL per_tl_term: got %h expected %h", v, 32'hFFFF_FFFF); end
        bus_read(A_TC0, v);
        n_cmp++; if (v !== 32'h3) begin n_err++; $display("FAIL per_pend_early: got %h expected %h", v, 32'h3); end
        tick(1);
        bus_read(A_TL0, v);
        n_cmp++; if (v !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL per_reload: got %h expected %h", v, 32'hFFFF_FFFD); end
        bus_read(A_TC0, v);
        n_cmp++; if (v !== 32'h7) begin n_err++; $display("FAIL per_pend: got %h expected %h", v, 32'h7); end
        n_cmp++; if (irqout !== 1'b1) begin n_err++; $display("FAIL per_irqout: got %b expected 1", irqout); end
        n_cmp++; if (irq_vec !== 2'b01) begin n_err++; $display("FAIL per_irqvec: got %b expected 01", irq_vec); end
        bus_write(A_TC0, 32'h7);
        bus_read(A_TC0, v);
        n_cmp++; if (v !== 32'h3) begin n_err++; $display("FAIL per_w1c: got %h expected %h", v, 32'h3); end
        bus_read(A_TL0, v);
        n_cmp++; if (v !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL per_tl_after_w1c: got %h expected %h", v, 32'hFFFF_FFFE); end
        tick(1);
        bus_write(A_TC0, 32'h7);
        bus_read(A_TC0, v);
        n_cmp++; if (v !== 32'h7) begin n_err++; $display("FAIL per_w1c_vs_term: got %h expected %h", v, 32'h7); end
        bus_write(A_TC0, 32'h4);
        bus_read(A_TC0, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL per_disable: got %h expected %h", v, 32'h0); end
        bus_read(A_TL0, v);
        n_cmp++; if (v !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL per_tl_final: got %h expected %h", v, 32'hFFFF_FFFE); end
    endtask

    task automatic test_oneshot;
        logic [31:0] v;
        bus_write(A_TL1, 32'hFFFF_FFFE);
        bus_write(A_TC1, 32'hB);
        tick(2);
        bus_read(A_TC1, v);
        n_cmp++; if (v !== 32'hE) begin n_err++; $display("FAIL os_tcon: got %h expected %h", v, 32'hE); end
        bus_read(A_TL1, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL os_reload: got %h expected %h", v, 32'h0); end
        tick(3);
        bus_read(A_TL1, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL os_frozen: got %h expected %h", v, 32'h0); end
        bus_read(A_IRQS, v);
        n_cmp++; if (v !== 32'h2) begin n_err++; $display("FAIL os_irqstat: got %h expected %h", v, 32'h2); end
        n_cmp++; if (irqout !== 1'b1) begin n_err++; $display("FAIL os_irqout: got %b expected 1", irqout); end
        bus_write(A_TC1, 32'h4);
        n_cmp++; if (irqout !== 1'b0) begin n_err++; $display("FAIL os_cleared_irq: got %b expected 0", irqout); end
    endtask

    task automatic test_mask_collision;
        logic [31:0] v;
        bus_write(A_TL0, 32'hFFFF_FFFF);
        bus_write(A_TC0, 32'h3);
        bus_write(A_TL0, 32'h10);
        bus_read(A_TL0, v);
        n_cmp++; if (v !== 32'h10) begin n_err++; $display("FAIL col_tl_write: got %h expected %h", v, 32'h10); end
        bus_read(A_TC0, v);
        n_cmp++; if (v !== 32'h7) begin n_err++; $display("FAIL col_pend: got %h expected %h", v, 32'h7); end
        irq_mask = 1'b1;
        #1;
        n_cmp++; if (irqout !== 1'b0) begin n_err++; $display("FAIL mask_irqout: got %b expected 0", irqout); end
        n_cmp++; if (irq_vec !== 2'b01) begin n_err++; $display("FAIL mask_irqvec: got %b expected 01", irq_vec); end
        irq_mask = 1'b0;
        #1;
        n_cmp++; if (irqout !== 1'b1) begin n_err++; $display("FAIL unmask_irqout: got %b expected 1", irqout); end
        bus_write(A_TC0, 32'h4);
        // TH write during a reload edge: the reload uses the old TH
        bus_write(A_TL0, 32'hFFFF_FFFF);
        bus_write(A_TC0, 32'h1);
        bus_write(A_TH0, 32'h20);
        bus_read(A_TL0, v);
        n_cmp++; if (v !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL col_th_old: got %h expected %h", v, 32'hFFFF_FFFD); end
        bus_read(A_TH0, v);
        n_cmp++; if (v !== 32'h20) begin n_err++; $display("FAIL col_th_new: got %h expected %h", v, 32'h20); end
        bus_read(A_TC0, v);
        n_cmp++; if (v !== 32'h5) begin n_err++; $display("FAIL col_th_pend: got %h expected %h", v, 32'h5); end
        // EN write during a one-shot terminal keeps the channel running
        bus_write(A_TC0, 32'h4);
        bus_write(A_TL0, 32'hFFFF_FFFF);
        bus_write(A_TC0, 32'h9);
        bus_write(A_TC0, 32'h9);
        bus_read(A_TC0, v);
        n_cmp++; if (v !== 32'hD) begin n_err++; $display("FAIL col_en_override: got %h expected %h", v, 32'hD); end
        bus_read(A_TL0, v);
        n_cmp++; if (v !== 32'h20) begin n_err++; $display("FAIL col_en_reload: got %h expected %h", v, 32'h20); end
        bus_write(A_TC0, 32'h4);
        bus_read(A_TL0, v);
        n_cmp++; if (v !== 32'h21) begin n_err++; $display("FAIL col_en_final_tl: got %h expected %h", v, 32'h21); end
    endtask

    task automatic test_held_terminal;
        logic [31:0] v;
        bus_write(A_TH0, 32'hFFFF_FFFF);
        bus_write(A_TL0, 32'hFFFF_FFFF);
        bus_write(A_TC0, 32'h1);
        tick(1);
        bus_write(A_TC0, 32'h5);
        bus_read(A_TC0, v);
        n_cmp++; if (v !== 32'h5) begin n_err++; $display("FAIL held_pend: got %h expected %h", v, 32'h5); end
        bus_read(A_TL0, v);
        n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL held_tl: got %h expected %h", v, 32'hFFFF_FFFF); end
        bus_write(A_TC0, 32'h4);
        bus_read(A_TC0, v);
        n_cmp++; if (v !== 32'h4) begin n_err++; $display("FAIL held_disable_pend: got %h expected %h", v, 32'h4); end
        bus_write(A_TC0, 32'h4);
        bus_read(A_TC0, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL held_clear: got %h expected %h", v, 32'h0); end
    endtask

    task automatic test_decode;
        logic [31:0] v;
        bus_write(BASE + 32'h0C, 32'hFFFF_FFFF);
        bus_write(BASE + 32'h108, 32'hFFFF_FFFF);
        bus_write(BASE + 32'h02, 32'h1234);
        bus_write(BASE + 32'h28, 32'hF);
        bus_write(BASE + 32'h100, 32'h0);
        bus_read(BASE + 32'h0C, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL dec_rd_0c: got %h expected %h", v, 32'h0); end
        bus_read(BASE + 32'h108, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL dec_rd_108: got %h expected %h", v, 32'h0); end
        bus_read(BASE + 32'h02, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL dec_rd_misalign: got %h expected %h", v, 32'h0); end
        bus_read(A_TH0, v);
        n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dec_th0: got %h expected %h", v, 32'hFFFF_FFFF); end
        bus_read(A_TL0, v);
        n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dec_tl0: got %h expected %h", v, 32'hFFFF_FFFF); end
        bus_read(A_TC0, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL dec_tcon0: got %h expected %h", v, 32'h0); end
        bus_read(A_TH1, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL dec_th1: got %h expected %h", v, 32'h0); end
        bus_read(A_TC1, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL dec_tcon1: got %h expected %h", v, 32'h0); end
        addr = A_TH0;
        rd   = 1'b0;
        #1;
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL dec_rd_idle: got %h expected %h", rdata, 32'h0); end
        addr = '0;
        // PEND shows in IRQSTAT without IE, but stays off irq_vec
        bus_write(A_TC0, 32'h1);
        tick(1);
        bus_read(A_IRQS, v);
        n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL irqstat_ch0: got %h expected %h", v, 32'h1); end
        n_cmp++; if (irq_vec !== 2'b00) begin n_err++; $display("FAIL irqvec_no_ie: got %b expected 00", irq_vec); end
        bus_write(A_TL1, 32'hFFFF_FFFF);
        bus_write(A_TC1, 32'h1);
        tick(1);
        bus_read(A_IRQS, v);
        n_cmp++; if (v !== 32'h3) begin n_err++; $display("FAIL irqstat_both: got %h expected %h", v, 32'h3); end
        bus_write(A_TC0, 32'h4);
        bus_write(A_TC1, 32'h4);
    endtask

    task automatic test_systick;
        logic [31:0] a;
        logic [31:0] b;
        bus_read(A_SYS, a);
        tick(7);
        bus_read(A_SYS, b);
        n_cmp++; if ((b - a) !== 32'd7) begin n_err++; $display("FAIL systick_delta: got %0d expected %0d", b - a, 7); end
    endtask

    task automatic test_prescale;
        logic [31:0] v;
        bus_write(A_TC1, 32'h4);
        bus_write(A_TL1, 32'h0);
`ifdef TIMER_PRESCALE_EN
        bus_write(A_TC1, 32'h0301);
        bus_read(A_TC1, v);
        n_cmp++; if (v !== 32'h0301) begin n_err++; $display("FAIL psc_tcon: got %h expected %h", v, 32'h0301); end
        tick(3);
        bus_read(A_TL1, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL psc_hold: got %h expected %h", v, 32'h0); end
        tick(1);
        bus_read(A_TL1, v);
        n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL psc_step: got %h expected %h", v, 32'h1); end
        tick(2);
        bus_write(A_TC1, 32'h0301);
        tick(3);
        bus_read(A_TL1, v);
        n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL psc_restart_hold: got %h expected %h", v, 32'h1); end
        tick(1);
        bus_read(A_TL1, v);
        n_cmp++; if (v !== 32'h2) begin n_err++; $display("FAIL psc_restart_step: got %h expected %h", v, 32'h2); end
`else
        bus_write(A_TC1, 32'hFF01);
        bus_read(A_TC1, v);
        n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL nopsc_tcon: got %h expected %h", v, 32'h1); end
        tick(3);
        bus_read(A_TL1, v);
        n_cmp++; if (v !== 32'h3) begin n_err++; $display("FAIL nopsc_count: got %h expected %h", v, 32'h3); end
`endif
        bus_write(A_TC1, 32'h4);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_periodic();
        test_oneshot();
        test_mask_collision();
        test_held_terminal();
        test_decode();
        test_systick();
        test_prescale();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
